// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
// Optional forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_IDX   = 0;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequenced clear engine: sweeps every entry to zero, one per cycle.
// Independent of REGFILE_BYPASS_EN.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req_i,
    output logic              busy_o,
    output logic              clr_done_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              busy_q;
    logic              done_q;

    assign cnt_d = cnt_q + ADDR_W'(1);

    // done_q is raised one edge early so it coincides with the last clear write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (clr_req_i) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_d;
                        done_q <= (cnt_d == LAST);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_done_o = done_q;
    assign clr_we_o   = (state_q == CLEAR);
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/reg_file_param.sv
// Two-read / one-write register file with async reset and clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module reg_file_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] wr_echo,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == ADDR_W'(ZERO_IDX));
    endfunction

    regfile_clear_fsm #(
        .ADDR_W(ADDR_W)
    ) u_clr (
        .clk       (clk),
        .rst       (rst),
        .clr_req_i (clr_req),
        .busy_o    (busy),
        .clr_done_o(clr_done),
        .clr_we_o  (clr_we),
        .clr_addr_o(clr_addr)
    );

    assign wr_ok = wr_en && !busy && !is_zero(wr_addr);

    // The sweep owns the write port; writeback is dropped while it runs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = is_zero(rd_addr_a) ? '0 : mem_q[rd_addr_a];
        rd_data_b = is_zero(rd_addr_b) ? '0 : mem_q[rd_addr_b];
        wr_echo   = is_zero(wr_addr)   ? '0 : mem_q[wr_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
        if (wr_ok && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Randomised and directed checks of reg_file_param against a behavioural model.
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic [31:0] rd_data_a, rd_data_b, wr_data, wr_echo;
    logic        wr_en, clr_req, busy, clr_done;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    logic [31:0] m [32];
    bit          m_busy;
    int          m_pos;

    always #5 clk = ~clk;

    reg_file_param dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_echo  (wr_echo),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && !m_busy && wr_addr == a) return wr_data;
`endif
        return m[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
        m_busy = 1'b0;
        m_pos  = 0;
    endtask

    // One clock: check outputs mid-cycle, advance model on the edge
    task automatic tick();
        #1;
        chk("rd_a", rd_data_a, exp_rd(rd_addr_a));
        chk("rd_b", rd_data_b, exp_rd(rd_addr_b));
        chk("echo", wr_echo, (wr_addr == 5'd0) ? 32'd0 : m[wr_addr]);
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("done", {31'd0, clr_done}, {31'd0, m_busy && m_pos == 31});
        if (busy) busy_cnt++;
        if (clr_done) done_cnt++;
        @(posedge clk);
        if (m_busy) begin
            m[m_pos] = 32'd0;
            if (m_pos == 31) m_busy = 1'b0;
            else m_pos++;
        end else begin
            if (wr_en && wr_addr != 5'd0) m[wr_addr] = wr_data;
            if (clr_req) begin
                m_busy = 1'b1;
                m_pos  = 0;
            end
        end
        @(negedge clk);
        wr_en   = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
    endtask

    // Assert reset away from the clock edge and verify everything reads zero
    task automatic reset_and_scan(input logic [4:0] first);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, clr_done}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = first + 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            chk("rst_rd_a", rd_data_a, 32'd0);
            chk("rst_rd_b", rd_data_b, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_sweep_to_end(input string tag);
        int guard = 0;
        while (busy && guard < 40) begin
            tick();
            guard++;
        end
        chk({tag, "_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rd_addr_a = '0; rd_addr_b = '0;
        wr_addr = '0; wr_data = '0;
        wr_en = 1'b0; clr_req = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        wr(5'd9, 32'h5555_AAAA);
        wr(5'd21, 32'h0BAD_F00D);
        reset_and_scan(5'd9);

        wr(5'd5, 32'hDEAD_BEEF);
        rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        #1;
        chk("w5_a", rd_data_a, 32'hDEAD_BEEF);
        chk("w5_b", rd_data_b, 32'hDEAD_BEEF);
        wr(5'd0, 32'h1234);
        rd_addr_a = 5'd0; wr_addr = 5'd0;
        #1;
        chk("r0", rd_data_a, 32'd0);
        chk("echo0", wr_echo, 32'd0);

        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
        rd_addr_a = 5'd10;
        rd_addr_b = 5'd31;
        busy_cnt = 0; done_cnt = 0;
        clr_req = 1'b1;
        tick();
        for (int k = 0; k < 40 && busy; k++) begin
            if (k == 3) begin
                wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hFFFF_0000;
            end
            if (k == 5) clr_req = 1'b1;
            #1;
            chk("r10", rd_data_a, (k <= 10) ? 32'd10 : 32'd0);
            tick();
        end
        chk("sweep_len", busy_cnt, 32);
        chk("done_cnt", done_cnt, 1);
        #1;
        chk("r31_end", rd_data_b, 32'd0);

        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 3));
        busy_cnt = 0; done_cnt = 0;
        clr_req = 1'b1;
        tick();
        for (int k = 0; k < 15; k++) tick();
        reset_and_scan(5'd16);
        chk("mid_rst_done", done_cnt, 0);
        busy_cnt = 0; done_cnt = 0;
        clr_req = 1'b1;
        tick();
        run_sweep_to_end("resweep");
        chk("resweep_len", busy_cnt, 32);
        chk("resweep_done", done_cnt, 1);

        wr(5'd7, 32'h11);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAA; rd_addr_a = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_a", rd_data_a, 32'hAA);
`else
        chk("byp_a", rd_data_a, 32'h11);
`endif
        chk("byp_echo", wr_echo, 32'h11);
        tick();
        #1;
        chk("byp_next", rd_data_a, 32'hAA);

        for (int n = 0; n < 600; n++) begin
            rd_addr_a = 5'($urandom);
            rd_addr_b = 5'($urandom);
            wr_addr   = ($urandom_range(0, 3) == 0) ? rd_addr_a : 5'($urandom);
            wr_data   = $urandom;
            wr_en     = 1'($urandom_range(0, 1));
            clr_req   = ($urandom_range(0, 59) == 0);
            tick();
        end
        run_sweep_to_end("rand");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
